// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and register scoreboard for the single regfile write port.
// Define WB_ARB_RR_EN for round-robin among requesters 1..NREQ-1 (else fixed priority).
module rf_wb_arbiter #(
   parameter int NREQ = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [5*NREQ-1:0]    req_addr,
   input  logic [32*NREQ-1:0]   req_data,
   input  logic                 issue_valid,
   input  logic [4:0]           issue_addr,
   output logic                 rf_we,
   output logic [4:0]           rf_waddr,
   output logic [31:0]          rf_wdata,
   output logic [31:0]          busy
);

   logic [NREQ-1:0] gnt;
   logic            found;
   logic            hs;
   logic [4:0]      sel_addr;
   logic [31:0]     sel_data;

   logic            rf_we_q,    rf_we_d;
   logic [4:0]      rf_waddr_q, rf_waddr_d;
   logic [31:0]     rf_wdata_q, rf_wdata_d;
   logic [31:0]     busy_q,     busy_d;

`ifdef WB_ARB_RR_EN
   localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;
   logic [PW-1:0]   ptr_q, ptr_d;

   // Two passes: from the pointer upward, then wrap to 1.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      if (req_valid[0]) begin
         gnt[0] = 1'b1;
         found  = 1'b1;
      end
      for (int i = 1; i < NREQ; i++) begin
         if (!found && req_valid[i] && i >= int'(ptr_q)) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
      for (int i = 1; i < NREQ; i++) begin
         if (!found && req_valid[i] && i < int'(ptr_q)) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      for (int i = 1; i < NREQ; i++) begin
         if (gnt[i]) ptr_d = (i == NREQ-1) ? PW'(1) : PW'(i+1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr_q <= PW'(1);
      else       ptr_q <= ptr_d;
   end
`else
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_valid[i]) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_addr = req_addr[5*i +: 5];
            sel_data = req_data[32*i +: 32];
         end
      end
   end

   assign hs = |gnt;

   // r0 handshakes complete but never reach the regfile.
   always_comb begin
      rf_we_d    = hs && (sel_addr != 5'd0);
      rf_waddr_d = hs ? sel_addr : rf_waddr_q;
      rf_wdata_d = hs ? sel_data : rf_wdata_q;
   end

   // Set after clear so a new producer keeps ownership.
   always_comb begin
      busy_d = busy_q;
      if (rf_we_q) busy_d[rf_waddr_q] = 1'b0;
      if (issue_valid && issue_addr != 5'd0) busy_d[issue_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         busy_q     <= '0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         busy_q     <= busy_d;
      end
   end

   assign req_ready = gnt;
   assign rf_we     = rf_we_q;
   assign rf_waddr  = rf_waddr_q;
   assign rf_wdata  = rf_wdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed-vector bench for rf_wb_arbiter.
// Covers reset, priority, contention, scoreboard lifecycle, collision and r0.
module tb_rf_wb_arbiter;

   localparam int NREQ = 3;

   logic              clk;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [5*NREQ-1:0] req_addr;
   logic [32*NREQ-1:0] req_data;
   logic              issue_valid;
   logic [4:0]        issue_addr;
   logic              rf_we;
   logic [4:0]        rf_waddr;
   logic [31:0]       rf_wdata;
   logic [31:0]       busy;

   int n_vec;
   int n_err;

   rf_wb_arbiter #(.NREQ(NREQ)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .issue_valid (issue_valid),
      .issue_addr  (issue_addr),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [4:0] a,
                          input logic [31:0] d);
      req_addr[5*i +: 5]   = a;
      req_data[32*i +: 32] = d;
   endtask

   logic [2:0] exp_gnt [4];
   logic [4:0] exp_adr [4];

   initial begin
      n_vec       = 0;
      n_err       = 0;
      reset       = 1'b1;
      req_valid   = '0;
      req_addr    = '0;
      req_data    = '0;
      issue_valid = 1'b0;
      issue_addr  = '0;

      tick();
      chk("rst_we",    {31'd0, rf_we}, 32'd0);
      chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
      chk("rst_busy",  busy, 32'd0);
      chk("rst_ready", {29'd0, req_ready}, 32'd0);
      reset = 1'b0;
      tick();

      // priority: requester 0 wins
      set_req(0, 5'd5, 32'hA);
      set_req(1, 5'd6, 32'hB);
      set_req(2, 5'd7, 32'hC);
      req_valid = 3'b111;
      #1;
      chk("prio_ready", {29'd0, req_ready}, 32'b001);
      tick();
      req_valid = '0;
      chk("prio_we",    {31'd0, rf_we}, 32'd1);
      chk("prio_waddr", {27'd0, rf_waddr}, 32'd5);
      chk("prio_wdata", rf_wdata, 32'hA);
      tick();
      chk("idle_we", {31'd0, rf_we}, 32'd0);
      chk("idle_hold", {27'd0, rf_waddr}, 32'd5);

      // contention between requesters 1 and 2
`ifdef WB_ARB_RR_EN
      exp_gnt = '{3'b010, 3'b100, 3'b010, 3'b100};
      exp_adr = '{5'd6, 5'd7, 5'd6, 5'd7};
`else
      exp_gnt = '{3'b010, 3'b010, 3'b010, 3'b010};
      exp_adr = '{5'd6, 5'd6, 5'd6, 5'd6};
`endif
      req_valid = 3'b110;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("cont_ready%0d", k), {29'd0, req_ready},
             {29'd0, exp_gnt[k]});
         tick();
         chk($sformatf("cont_waddr%0d", k), {27'd0, rf_waddr},
             {27'd0, exp_adr[k]});
      end
      req_valid = '0;
      tick();

      // scoreboard lifecycle on r9
      issue_valid = 1'b1;
      issue_addr  = 5'd9;
      tick();
      issue_valid = 1'b0;
      chk("sb_set", busy, 32'h0000_0200);
      tick();
      tick();
      chk("sb_hold", busy, 32'h0000_0200);
      set_req(1, 5'd9, 32'h99);
      req_valid = 3'b010;
      #1;
      chk("sb_ready", {29'd0, req_ready}, 32'b010);
      tick();
      req_valid = '0;
      chk("sb_we", {31'd0, rf_we}, 32'd1);
      chk("sb_waddr", {27'd0, rf_waddr}, 32'd9);
      chk("sb_busy_n1", busy, 32'h0000_0200);
      tick();
      chk("sb_clr", busy, 32'd0);

      // set/clear collision on r12
      issue_valid = 1'b1;
      issue_addr  = 5'd12;
      tick();
      issue_valid = 1'b0;
      set_req(1, 5'd12, 32'h12);
      req_valid = 3'b010;
      tick();
      req_valid = '0;
      chk("col_we", {31'd0, rf_we}, 32'd1);
      issue_valid = 1'b1;
      issue_addr  = 5'd12;
      tick();
      issue_valid = 1'b0;
      chk("col_busy", busy, 32'h0000_1000);
      req_valid = 3'b010;
      tick();
      req_valid = '0;
      tick();
      chk("col_clr", busy, 32'd0);

      // r0 handling
      issue_valid = 1'b1;
      issue_addr  = 5'd0;
      tick();
      issue_valid = 1'b0;
      chk("r0_busy", busy, 32'd0);
      set_req(2, 5'd0, 32'hDEAD);
      req_valid = 3'b100;
      #1;
      chk("r0_ready", {29'd0, req_ready}, 32'b100);
      tick();
      req_valid = '0;
      chk("r0_we", {31'd0, rf_we}, 32'd0);

      // asynchronous reset mid-operation
      issue_valid = 1'b1;
      issue_addr  = 5'd4;
      tick();
      issue_valid = 1'b0;
      set_req(1, 5'd3, 32'h33);
      req_valid = 3'b010;
      tick();
      req_valid = '0;
      chk("pre_we", {31'd0, rf_we}, 32'd1);
      chk("pre_busy", busy, 32'h0000_0010);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_we",    {31'd0, rf_we}, 32'd0);
      chk("arst_busy",  busy, 32'd0);
      chk("arst_waddr", {27'd0, rf_waddr}, 32'd0);
      tick();
      reset = 1'b0;
      req_valid = 3'b010;
      #1;
      chk("post_ready", {29'd0, req_ready}, 32'b010);
      req_valid = 3'b110;
      #1;
      chk("post_rr", {29'd0, req_ready}, 32'b010);
      req_valid = '0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
